// File: rtl/interleaver_pkg.sv
// Shared constants, state type and sync-byte helper for the interleaver scheduler.
// No logic of its own; latency and backpressure are defined by the users of this package.
package interleaver_pkg;

   localparam logic [7:0] SYNC_BYTE       = 8'h47;
   localparam logic [7:0] SYNC_BYTE_INV   = 8'hB8;
   localparam int         DEFAULT_PKT_LEN = 204;

   typedef enum logic {S_IDLE, S_XFER} sched_state;

   function automatic logic is_sync(input logic [7:0] b);
      return (b == SYNC_BYTE) || (b == SYNC_BYTE_INV);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo NUM_CH.
// Latency: purely combinational. Backpressure: none, gnt_valid low when nothing requests.
module rr_arbiter #(
   parameter int NUM_CH = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [2:0]        ptr,
   output logic [2:0]        gnt_id,
   output logic              gnt_valid
);

   // Walk from farthest to nearest so the nearest requester is written last and wins.
   always_comb begin
      int idx;
      gnt_id    = '0;
      gnt_valid = 1'b0;
      idx       = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (req[idx]) begin
            gnt_id    = 3'(idx);
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interleaver_scheduler.sv
// Packet round-robin share of one interleaver port among NUM_CH byte streams; INTLV_SCHED_TIMEOUT_EN adds stall abort.
// Latency: data/rdy/acpt muxed combinationally; first handshake one cycle after a request in IDLE, zero bubble between packets.
// Backpressure: il_di_acpt goes straight to the granted ch_acpt; stalls hold grant and byte count (or abort on timeout).
module interleaver_scheduler
   import interleaver_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int PKT_LEN     = DEFAULT_PKT_LEN,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_CH-1:0]     ch_rdy,
   output logic [NUM_CH-1:0]     ch_acpt,
   input  logic [8*NUM_CH-1:0]   ch_data,
   input  logic [NUM_CH-1:0]     ch_enable,
   output logic                  il_di_rdy,
   input  logic                  il_di_acpt,
   output logic [7:0]            il_di,
   output logic                  il_enable,
   output logic [2:0]            grant_id,
   output logic                  busy,
   output logic                  pkt_done,
   output logic                  sync_err,
`ifdef INTLV_SCHED_TIMEOUT_EN
   output logic                  timeout,
`endif
   output logic [NUM_CH-1:0]     sync_err_sticky
);

   if (NUM_CH < 2 || NUM_CH > 8 || PKT_LEN < 2 || PKT_LEN > 255 || TIMEOUT_CYC < 2) begin : g_param_err
      $error("interleaver_scheduler: parameter out of range");
   end

   sched_state state;
   logic [7:0] byte_cnt;
   logic [2:0] rr_ptr, ptr_adv, arb_ptr, arb_id;
   logic       arb_vld, hs, last_byte, first_bad, abort, pkt_end;

   assign busy      = (state == S_XFER);
   assign il_di_rdy = busy && ch_rdy[grant_id];
   assign il_di     = ch_data[8*grant_id +: 8];
   assign hs        = il_di_rdy && il_di_acpt;
   assign last_byte = hs && (byte_cnt == 8'(PKT_LEN - 1));
   assign first_bad = hs && (byte_cnt == 8'd0) && !is_sync(il_di);
   assign pkt_end   = last_byte || abort;

   always_comb begin
      ch_acpt = '0;
      for (int i = 0; i < NUM_CH; i++)
         ch_acpt[i] = busy && (grant_id == 3'(i)) && il_di_acpt;
   end

   // At packet end the search must already skip the channel that just finished.
   assign ptr_adv = (grant_id == 3'(NUM_CH - 1)) ? 3'd0 : grant_id + 3'd1;
   assign arb_ptr = busy ? ptr_adv : rr_ptr;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req       (ch_rdy),
      .ptr       (arb_ptr),
      .gnt_id    (arb_id),
      .gnt_valid (arb_vld)
   );

`ifdef INTLV_SCHED_TIMEOUT_EN
   logic [15:0] stall_cnt;

   assign abort = busy && !hs && (stall_cnt == 16'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         timeout   <= 1'b0;
      end else begin
         timeout <= abort;
         if (hs || !busy || pkt_end) stall_cnt <= '0;
         else                        stall_cnt <= stall_cnt + 16'd1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         byte_cnt        <= '0;
         grant_id        <= '0;
         rr_ptr          <= '0;
         il_enable       <= 1'b0;
         pkt_done        <= 1'b0;
         sync_err        <= 1'b0;
         sync_err_sticky <= '0;
      end else begin
         pkt_done <= last_byte;
         sync_err <= first_bad;
         if (first_bad) sync_err_sticky[grant_id] <= 1'b1;

         if (state == S_IDLE) begin
            if (arb_vld) begin
               state     <= S_XFER;
               byte_cnt  <= '0;
               grant_id  <= arb_id;
               il_enable <= ch_enable[arb_id];
            end
         end else if (pkt_end) begin
            byte_cnt <= '0;
            rr_ptr   <= ptr_adv;
            if (arb_vld) begin
               grant_id  <= arb_id;
               il_enable <= ch_enable[arb_id];
            end else begin
               state <= S_IDLE;
            end
         end else if (hs) begin
            byte_cnt <= byte_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_interleaver_scheduler.sv
// Bench for interleaver_scheduler: directed vector table, reset/timeout sequences, and a random run
// checked every cycle against a packet-level reference model.
module tb_interleaver_scheduler;
   import interleaver_pkg::*;

   localparam int NUM_CH      = 2;
   localparam int PKT_LEN     = 204;
   localparam int TIMEOUT_CYC = 16;
`ifdef INTLV_SCHED_TIMEOUT_EN
   localparam int STALL_LEN   = 10;
`else
   localparam int STALL_LEN   = 50;
`endif

   logic              clk;
   logic              reset_n;
   logic [1:0]        ch_rdy, ch_acpt, ch_enable, sync_err_sticky;
   logic [7:0]        d0, d1;
   logic [15:0]       ch_data;
   logic              il_di_rdy, il_di_acpt, il_enable, busy, pkt_done, sync_err;
   logic [7:0]        il_di;
   logic [2:0]        grant_id;
   logic              timeout_s;

   assign ch_data = {d1, d0};

   interleaver_scheduler #(.NUM_CH(NUM_CH), .PKT_LEN(PKT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .ch_rdy          (ch_rdy),
      .ch_acpt         (ch_acpt),
      .ch_data         (ch_data),
      .ch_enable       (ch_enable),
      .il_di_rdy       (il_di_rdy),
      .il_di_acpt      (il_di_acpt),
      .il_di           (il_di),
      .il_enable       (il_enable),
      .grant_id        (grant_id),
      .busy            (busy),
      .pkt_done        (pkt_done),
      .sync_err        (sync_err),
`ifdef INTLV_SCHED_TIMEOUT_EN
      .timeout         (timeout_s),
`endif
      .sync_err_sticky (sync_err_sticky)
   );
`ifndef INTLV_SCHED_TIMEOUT_EN
   assign timeout_s = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   wire logic [20:0] act_v = {grant_id, busy, il_enable, il_di_rdy, ch_acpt, il_di,
                              pkt_done, sync_err, sync_err_sticky, timeout_s};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   function automatic logic [20:0] mk(input logic [2:0] g, input logic b, input logic en,
                                      input logic r, input logic [1:0] a, input logic [7:0] di,
                                      input logic dn, input logic se, input logic [1:0] st);
      return {g, b, en, r, a, di, dn, se, st, 1'b0};
   endfunction

   // First requesting channel found scanning upward from 'start', wrapping; -1 if none.
   function automatic int pick(input logic [1:0] req, input int start);
      for (int k = 0; k < NUM_CH; k++)
         if (req[(start + k) % NUM_CH]) return (start + k) % NUM_CH;
      return -1;
   endfunction

   function automatic logic [7:0] rnd_byte();
      case ($urandom_range(0, 2))
         0:       return 8'h47;
         1:       return 8'hB8;
         default: return 8'($urandom);
      endcase
   endfunction

   // Reference model: which channel owns the port, how many bytes of its packet have gone,
   // whose turn is next, plus the pulses that the last clock edge should have produced.
   bit       mon_en = 1'b0;
   bit       m_busy, m_en, m_done, m_serr, m_to;
   int       m_gid, m_cnt, m_ptr, m_stall;
   bit [1:0] m_sticky;

   always @(negedge clk) begin
      logic [7:0]  d;
      logic        hs_m, fin;
      int          w;
      logic [20:0] e;
      if (!reset_n) begin
         m_busy = 0; m_en = 0; m_done = 0; m_serr = 0; m_to = 0;
         m_gid = 0; m_cnt = 0; m_ptr = 0; m_stall = 0; m_sticky = '0;
      end
      d    = (m_gid == 0) ? d0 : d1;
      hs_m = m_busy && ch_rdy[m_gid] && il_di_acpt;
      e    = {3'(m_gid), m_busy, m_en, m_busy && ch_rdy[m_gid],
              (m_busy && il_di_acpt) ? 2'(1 << m_gid) : 2'b00,
              d, m_done, m_serr, m_sticky, m_to};
      if (mon_en) chk("monitor", 32'(act_v), 32'(e));
      if (reset_n) begin
         m_done = 0; m_serr = 0; m_to = 0; fin = 0;
         if (!m_busy) begin
            w = pick(ch_rdy, m_ptr);
            if (w >= 0) begin
               m_busy = 1; m_gid = w; m_en = ch_enable[w]; m_cnt = 0; m_stall = 0;
            end
         end else begin
            if (hs_m) begin
               if (m_cnt == 0 && d != 8'h47 && d != 8'hB8) begin
                  m_serr = 1; m_sticky[m_gid] = 1'b1;
               end
               m_stall = 0;
               m_cnt++;
               if (m_cnt == PKT_LEN) begin m_done = 1; fin = 1; end
            end else begin
               m_stall++;
`ifdef INTLV_SCHED_TIMEOUT_EN
               if (m_stall == TIMEOUT_CYC) begin m_to = 1; fin = 1; end
`endif
            end
            if (fin) begin
               m_cnt = 0; m_stall = 0;
               m_ptr = (m_gid + 1) % NUM_CH;
               w = pick(ch_rdy, m_ptr);
               if (w >= 0) begin m_gid = w; m_en = ch_enable[w]; end
               else m_busy = 0;
            end
         end
      end
   end

   typedef struct {
      logic [1:0]  rdy;
      logic [1:0]  en;
      logic [7:0]  b0;
      logic [7:0]  b1;
      int          n;
      logic [20:0] exp;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int hold_lo;
      tbl[0] = '{2'b00, 2'b11, 8'h47, 8'h47, 3,         mk(3'd0, 0, 0, 0, 2'b00, 8'h47, 0, 0, 2'b00)};
      tbl[1] = '{2'b01, 2'b01, 8'h47, 8'h00, 1,         mk(3'd0, 1, 1, 1, 2'b01, 8'h47, 0, 0, 2'b00)};
      tbl[2] = '{2'b01, 2'b01, 8'h47, 8'h00, 203,       mk(3'd0, 1, 1, 1, 2'b01, 8'h47, 0, 0, 2'b00)};
      tbl[3] = '{2'b11, 2'b01, 8'h47, 8'h00, 1,         mk(3'd1, 1, 0, 1, 2'b10, 8'h00, 1, 0, 2'b00)};
      tbl[4] = '{2'b11, 2'b01, 8'h47, 8'h00, 1,         mk(3'd1, 1, 0, 1, 2'b10, 8'h00, 0, 1, 2'b10)};
      tbl[5] = '{2'b11, 2'b10, 8'h47, 8'h00, 203,       mk(3'd0, 1, 0, 1, 2'b01, 8'h47, 1, 0, 2'b10)};
      tbl[6] = '{2'b10, 2'b11, 8'h47, 8'h00, STALL_LEN, mk(3'd0, 1, 0, 0, 2'b01, 8'h47, 0, 0, 2'b10)};
      tbl[7] = '{2'b11, 2'b11, 8'h47, 8'h00, 204,       mk(3'd1, 1, 1, 1, 2'b10, 8'h00, 1, 0, 2'b10)};

      reset_n = 1'b0; ch_rdy = '0; ch_enable = '0; d0 = '0; d1 = '0; il_di_acpt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", 32'(act_v), 32'(21'h0));
      mon_en = 1'b1;
      @(posedge clk); #1;
      reset_n = 1'b1;
      il_di_acpt = 1'b1;

      for (int r = 0; r < 8; r++) begin
         ch_rdy = tbl[r].rdy; ch_enable = tbl[r].en; d0 = tbl[r].b0; d1 = tbl[r].b1;
         repeat (tbl[r].n) @(posedge clk);
         #1;
         chk($sformatf("vec%0d", r), 32'(act_v), 32'(tbl[r].exp));
      end

      // Reset in the middle of channel 1's packet, then a clean restart from channel 0.
      repeat (57) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("reset_mid_pkt", 32'(act_v), 32'(mk(3'd0, 0, 0, 0, 2'b00, 8'h47, 0, 0, 2'b00)));
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_grant", {grant_id, busy, pkt_done}, {3'd0, 1'b1, 1'b0});
      repeat (203) @(posedge clk);
      #1;
      chk("post_reset_cnt203", {grant_id, pkt_done}, {3'd0, 1'b0});
      @(posedge clk); #1;
      chk("post_reset_pkt_end", {grant_id, pkt_done}, {3'd1, 1'b1});

`ifdef INTLV_SCHED_TIMEOUT_EN
      il_di_acpt = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("timeout_not_yet", {timeout_s, grant_id}, {1'b0, 3'd1});
      @(posedge clk); #1;
      chk("timeout_abort", {timeout_s, pkt_done, grant_id}, {1'b1, 1'b0, 3'd0});
      il_di_acpt = 1'b1;
`endif

      hold_lo = 0;
      for (int c = 0; c < 5000 && failures < 40; c++) begin
         @(posedge clk); #1;
         reset_n = ($urandom_range(0, 1499) != 0);
         for (int i = 0; i < NUM_CH; i++)
            if ($urandom_range(0, 99) < 15) ch_rdy[i] = ~ch_rdy[i];
         ch_enable = 2'($urandom);
         d0 = rnd_byte();
         d1 = rnd_byte();
         if (hold_lo > 0) begin
            hold_lo--;
            il_di_acpt = 1'b0;
         end else if ($urandom_range(0, 99) < 2) begin
            hold_lo = $urandom_range(5, 25);
            il_di_acpt = 1'b0;
         end else begin
            il_di_acpt = ($urandom_range(0, 99) < 85);
         end
      end

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
